// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// width and the 4-bit carry-lookahead cell used by the trial subtractor.
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // 4-bit lookahead cell: returns {c4, c3, c2, c1} from per-bit g/p and carry-in.
  function automatic logic [3:0] clb4(input logic [3:0] g, input logic [3:0] p,
                                      input logic cin);
    logic c1, c2, c3, c4;
    c1 = g[0] | (p[0] & cin);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c4, c3, c2, c1};
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/ready/valid handshake bundle between an issuing unit and the divider.
interface seq_divider_if import div_pkg::*; #(parameter int W = DIV_W);

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         valid;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         div_zero;

  modport master (output start, A, B, input ready, valid, Q, R, div_zero);
  modport slave  (input start, A, B, output ready, valid, Q, R, div_zero);

endinterface

// File: rtl/sub_trial.sv
// Combinational N-bit trial subtract a - b = a + ~b + 1 on 4-bit lookahead
// cells, groups chained by their carry-out. borrow is the inverted carry-out.
module sub_trial import div_pkg::*; #(
  parameter int N = DIV_W + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NG = (N + 3) / 4;
  localparam int NP = NG * 4;

  logic [NP-1:0] g;
  logic [NP-1:0] p;
  logic [N:0]    c;

  // Generate/propagate pre-processing, then lookahead carries group by group.
  always_comb begin
    logic [3:0] cv;
    logic       cin_v;
    g = '0;
    p = '0;
    g[N-1:0] = a & ~b;
    p[N-1:0] = a ^ ~b;
    c = '0;
    c[0] = 1'b1;
    cin_v = 1'b1;
    cv = '0;
    for (int i = 0; i < NG; i++) begin
      cv = clb4(g[i*4 +: 4], p[i*4 +: 4], cin_v);
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k < N) c[i*4+k+1] = cv[k];
      end
      cin_v = cv[3];
    end
  end

  assign diff   = p[N-1:0] ^ c[N-1:0];
  assign borrow = ~c[N];

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock.
//
// state | meaning
// IDLE  | ready for a new divide; operands captured on start
// RUN   | one shift/trial-subtract iteration per cycle
// DONE  | results presented, valid high for this single cycle
//
// A zero divisor is routed through a single RUN pass (counter preloaded to
// its last value) so its result lands one edge after acceptance.
module seq_divider import div_pkg::*; #(
  parameter int W  = DIV_W,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  div_state_e    state, state_nxt;
  logic [CW-1:0] counter;
  logic [W:0]    p_reg;
  logic [W-1:0]  qsh;
  logic [W-1:0]  bd;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  r_reg;
  logic          dz_reg;

  logic [W:0]    p_sh;
  logic [W:0]    d;
  logic [W:0]    p_next;
  logic [W-1:0]  qsh_next;
  logic          borrow;
  logic          last;
  logic          is_idle;
  logic          is_done;

  assign p_sh     = (p_reg << 1) | {{W{1'b0}}, qsh[W-1]};
  assign p_next   = borrow ? p_sh : d;
  assign qsh_next = {qsh[W-2:0], ~borrow};
  assign last     = (counter == CW'(W - 1));

  sub_trial #(.N(W + 1)) u_sub_trial (
    .a      (p_sh),
    .b      ({1'b0, bd}),
    .diff   (d),
    .borrow (borrow)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    is_idle   = 1'b0;
    is_done   = 1'b0;
    case (state)
      IDLE: begin
        is_idle = 1'b1;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        is_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      p_reg   <= '0;
      qsh     <= '0;
      bd      <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dz_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            qsh     <= bus.A;
            bd      <= bus.B;
            p_reg   <= '0;
            counter <= (bus.B == '0) ? CW'(W - 1) : '0;
          end
        end
        RUN: begin
          p_reg   <= p_next;
          qsh     <= qsh_next;
          counter <= counter + CW'(1);
          if (last) begin
            if (bd == '0) begin
              q_reg  <= '1;
              r_reg  <= qsh;
              dz_reg <= 1'b1;
            end else begin
              q_reg  <= qsh_next;
              r_reg  <= p_next[W-1:0];
              dz_reg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = is_idle;
  assign bus.valid    = is_done;
  assign bus.Q        = q_reg;
  assign bus.R        = r_reg;
  assign bus.div_zero = dz_reg;

endmodule
